// File: rtl/prof_cmd_issuer_pkg.sv
// Shared definitions for the profiling command issuer: counter command codes,
// issuer state encoding, timestamp width and the reserved end-of-run tag.
package prof_pkg;

  localparam int TS_W     = 64;
  localparam int MAX_TAGW = 32;

  localparam logic [3:0] CMD_NOP  = 4'h0;
  localparam logic [3:0] CMD_STOP = 4'h2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    SYNC = 3'd2,
    RUN  = 3'd3,
    STOP = 3'd4
  } state_e;

  // All-ones tag of width tagw, right-aligned in a MAX_TAGW-bit word.
  function automatic logic [MAX_TAGW-1:0] END_TAG(input int tagw);
    END_TAG = '0;
    for (int i = 0; i < MAX_TAGW; i++) begin
      if (i < tagw) END_TAG[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/prof_cmd_issuer_if.sv
// Host, counter-unit and record-readout signals of the profiling command issuer.
// master = host plus counter unit; slave = the issuer.
interface prof_cmd_issuer_if #(
  parameter int DEPTH = 16,
  parameter int TAGW  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     host_start;
  logic                     host_sample;
  logic                     host_stop;
  logic [TAGW-1:0]          host_tag;
  logic                     busy;

  logic                     ts_start;
  logic [3:0]               ts_command;
  logic                     ts_done;
  logic [prof_pkg::TS_W-1:0] ts_timestamp;

  // Readout handshake: the head record is popped on a rising edge where rd_valid
  // and rd_en are both high; rd_en while rd_valid is low is ignored, and the head
  // (rd_timestamp/rd_tag) holds steady while rd_valid is high and rd_en is low.
  logic                     rd_valid;
  logic                     rd_en;
  logic [prof_pkg::TS_W-1:0] rd_timestamp;
  logic [TAGW-1:0]          rd_tag;
  logic [CW-1:0]            count;
  logic                     overflow;

  prof_pkg::state_e         dbg_state;

  modport master (
    output host_start, host_sample, host_stop, host_tag, ts_done, ts_timestamp, rd_en,
    input  busy, ts_start, ts_command, rd_valid, rd_timestamp, rd_tag, count, overflow,
           dbg_state
  );

  modport slave (
    input  host_start, host_sample, host_stop, host_tag, ts_done, ts_timestamp, rd_en,
    output busy, ts_start, ts_command, rd_valid, rd_timestamp, rd_tag, count, overflow,
           dbg_state
  );

endinterface

// File: rtl/prof_cmd_issuer_rec_fifo.sv
// First-word-fall-through record FIFO with flush, occupancy count and a sticky
// overflow flag; a write into a full FIFO is kept only if a pop frees a slot.
module prof_rec_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 72
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [DW-1:0]            rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, do_wr, do_rd;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_rd    = rd_en_i & ~empty & ~flush_i;
    do_wr    = wr_en_i & ~flush_i & (~full | do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_wr && !do_rd)      count_d = count_q + CW'(1);
      else if (!do_wr && do_rd) count_d = count_q - CW'(1);
      if (wr_en_i && full && !do_rd) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = ~empty;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/prof_cmd_issuer.sv
// Profiling command issuer: turns host start/sample/stop requests into the
// counter unit's start pulse and stop command, logging timestamps into a FIFO.
module prof_cmd_issuer
  import prof_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAGW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  prof_cmd_issuer_if.slave bus
);
  localparam logic [MAX_TAGW-1:0] END_TAG_W = END_TAG(TAGW);

  state_e          state_q, state_d;
  logic            ts_start_q, ts_start_d;
  logic [3:0]      ts_cmd_q, ts_cmd_d;
  logic            flush, wr_en;
  logic [TAGW-1:0] wr_tag;

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_tag  = bus.host_tag;
    case (state_q)
      IDLE: begin
        if (bus.host_start) begin
          state_d = ARM;
          flush   = 1'b1;
        end
      end
      ARM:  state_d = SYNC;
      SYNC: if (!bus.ts_done) state_d = RUN;
      RUN: begin
        wr_en = bus.host_sample;
        if (bus.host_stop) state_d = STOP;
      end
      STOP: begin
        if (bus.ts_done) begin
          wr_en   = 1'b1;
          wr_tag  = END_TAG_W[TAGW-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Counter-unit outputs are registered copies of what the next state implies.
    ts_start_d = (state_d == ARM);
    ts_cmd_d   = (state_d == STOP) ? CMD_STOP : CMD_NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ts_start_q <= 1'b0;
      ts_cmd_q   <= CMD_NOP;
    end else begin
      state_q    <= state_d;
      ts_start_q <= ts_start_d;
      ts_cmd_q   <= ts_cmd_d;
    end
  end

  prof_rec_fifo #(
    .DEPTH (DEPTH),
    .DW    (TS_W + TAGW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .wr_en_i    (wr_en),
    .wr_data_i  ({bus.ts_timestamp, wr_tag}),
    .rd_en_i    (bus.rd_en),
    .rd_valid_o (bus.rd_valid),
    .rd_data_o  ({bus.rd_timestamp, bus.rd_tag}),
    .count_o    (bus.count),
    .overflow_o (bus.overflow)
  );

  assign bus.busy       = (state_q != IDLE);
  assign bus.ts_start   = ts_start_q;
  assign bus.ts_command = ts_cmd_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_prof_cmd_issuer.sv
// Bench for prof_cmd_issuer (DEPTH=4): counter-unit model, queue-based reference
// model, vector table, directed corner sequences and randomized runs.
module tb_prof_cmd_issuer;
  import prof_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAGW  = 8;
  localparam int DW    = TS_W + TAGW;
  localparam int M_IDLE = 0, M_ARM = 1, M_SYNC = 2, M_RUN = 3, M_STOP = 4;

  logic clk, rst;

  prof_cmd_issuer_if #(.DEPTH(DEPTH), .TAGW(TAGW)) bus();
  prof_cmd_issuer #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // counter-unit model
  logic        counting, arming;
  int          arm_left, stop_left, start_lat, stop_lat;
  logic [63:0] cnt;

  // reference model
  int          phase;
  logic        ovf_m;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic st, sm, sp; logic [7:0] tg; logic rd;
    logic e_busy, e_start; logic [3:0] e_cmd; int e_count; logic e_ovf;
    logic e_head; logic [63:0] e_ts; logic [7:0] e_tag;
  } vec_t;
  vec_t vecs[18];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic counter_update();
    if (bus.ts_start === 1'b1) begin
      arming = 1'b1; arm_left = start_lat; counting = 1'b0; cnt = '0; stop_left = stop_lat;
    end
    if (arming) begin
      if (arm_left == 0) begin arming = 1'b0; counting = 1'b1; end
      else arm_left--;
    end else if (counting) begin
      if (bus.ts_command === CMD_STOP) begin
        if (stop_left == 0) counting = 1'b0;
        else begin stop_left--; cnt++; end
      end else cnt++;
    end
    bus.ts_done      = !counting;
    bus.ts_timestamp = cnt;
  endtask

  // What the next rising edge does to the run phase and the record list.
  task automatic model_step();
    logic wr, flush;
    logic [DW-1:0] d;
    wr = 1'b0; flush = 1'b0;
    d = {bus.ts_timestamp, bus.host_tag};
    case (phase)
      M_IDLE: if (bus.host_start) begin phase = M_ARM; flush = 1'b1; end
      M_ARM:  phase = M_SYNC;
      M_SYNC: if (!bus.ts_done) phase = M_RUN;
      M_RUN: begin
        wr = bus.host_sample;
        if (bus.host_stop) phase = M_STOP;
      end
      M_STOP: if (bus.ts_done) begin wr = 1'b1; d = {bus.ts_timestamp, 8'hFF}; phase = M_IDLE; end
      default: ;
    endcase
    if (flush) begin
      exp_q.delete(); ovf_m = 1'b0;
    end else begin
      if (bus.rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (wr) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else ovf_m = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    check("busy", bus.busy, phase != M_IDLE);
    check("ts_start", bus.ts_start, phase == M_ARM);
    check("ts_command", bus.ts_command, (phase == M_STOP) ? CMD_STOP : CMD_NOP);
    check("count", bus.count, exp_q.size());
    check("rd_valid", bus.rd_valid, exp_q.size() > 0);
    check("overflow", bus.overflow, ovf_m);
    if (exp_q.size() > 0) check("head", {bus.rd_timestamp, bus.rd_tag}, exp_q[0]);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic st, input logic sm, input logic sp,
                      input logic [7:0] tg, input logic rd);
    bus.host_start = st; bus.host_sample = sm; bus.host_stop = sp;
    bus.host_tag = tg; bus.rd_en = rd;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
    counter_update();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.host_start = 1'b0; bus.host_sample = 1'b0; bus.host_stop = 1'b0;
    bus.host_tag = '0; bus.rd_en = 1'b0;
    counting = 1'b0; arming = 1'b0; cnt = '0; arm_left = 0; stop_left = 0;
    bus.ts_done = 1'b1; bus.ts_timestamp = '0;
    phase = M_IDLE; exp_q.delete(); ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input logic [63:0] target);
    int g = 0;
    while (bus.ts_timestamp != target && g < 200) begin idle_step(); g++; end
    check("wait_cnt", bus.ts_timestamp, target);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (phase != M_IDLE && g < 100) begin idle_step(); g++; end
    check("stop_timeout", bus.busy, 1'b0);
  endtask

  task automatic read_expect(input string name, input logic [63:0] ts, input logic [7:0] tg);
    check(name, {bus.rd_timestamp, bus.rd_tag}, {ts, tg});
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  function automatic void set_vec(input int i, input logic st, input logic sm, input logic sp,
      input logic [7:0] tg, input logic rd, input logic b, input logic s, input logic [3:0] c,
      input int n, input logic o, input logic h, input logic [63:0] ts, input logic [7:0] t);
    vecs[i] = '{st, sm, sp, tg, rd, b, s, c, n, o, h, ts, t};
  endfunction

  initial begin
    start_lat = 0; stop_lat = 0;
    do_reset();
    check_model();
    check("reset_ts_command", bus.ts_command, CMD_NOP);

    //           st sm sp tag   rd  busy strt cmd  cnt ovf head ts  tag
    set_vec( 0, 1, 0, 0, 8'h00, 0,  1, 1, 4'h0, 0, 0, 0, 0, 8'h00);
    set_vec( 1, 0, 0, 0, 8'h00, 0,  1, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    set_vec( 2, 0, 1, 0, 8'h33, 0,  1, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    set_vec( 3, 0, 1, 0, 8'h05, 0,  1, 0, 4'h0, 1, 0, 1, 2, 8'h05);
    set_vec( 4, 1, 1, 0, 8'h06, 0,  1, 0, 4'h0, 2, 0, 1, 2, 8'h05);
    set_vec( 5, 0, 1, 0, 8'h07, 1,  1, 0, 4'h0, 2, 0, 1, 3, 8'h06);
    set_vec( 6, 0, 1, 0, 8'h08, 0,  1, 0, 4'h0, 3, 0, 1, 3, 8'h06);
    set_vec( 7, 0, 1, 0, 8'h09, 0,  1, 0, 4'h0, 4, 0, 1, 3, 8'h06);
    set_vec( 8, 0, 1, 0, 8'h0A, 0,  1, 0, 4'h0, 4, 1, 1, 3, 8'h06);
    set_vec( 9, 0, 1, 0, 8'h0B, 1,  1, 0, 4'h0, 4, 1, 1, 4, 8'h07);
    set_vec(10, 0, 0, 1, 8'h00, 0,  1, 0, 4'h2, 4, 1, 1, 4, 8'h07);
    set_vec(11, 0, 0, 0, 8'h00, 1,  0, 0, 4'h0, 4, 1, 1, 5, 8'h08);
    set_vec(12, 0, 0, 0, 8'h00, 1,  0, 0, 4'h0, 3, 1, 1, 6, 8'h09);
    set_vec(13, 0, 0, 0, 8'h00, 1,  0, 0, 4'h0, 2, 1, 1, 8, 8'h0B);
    set_vec(14, 0, 1, 1, 8'h00, 1,  0, 0, 4'h0, 1, 1, 1, 9, 8'hFF);
    set_vec(15, 0, 0, 0, 8'h00, 1,  0, 0, 4'h0, 0, 1, 0, 0, 8'h00);
    set_vec(16, 0, 0, 0, 8'h00, 1,  0, 0, 4'h0, 0, 1, 0, 0, 8'h00);
    set_vec(17, 1, 0, 0, 8'h00, 0,  1, 1, 4'h0, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].st, vecs[i].sm, vecs[i].sp, vecs[i].tg, vecs[i].rd);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].e_busy);
      check($sformatf("vec%0d_ts_start", i), bus.ts_start, vecs[i].e_start);
      check($sformatf("vec%0d_ts_command", i), bus.ts_command, vecs[i].e_cmd);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].e_count);
      check($sformatf("vec%0d_rd_valid", i), bus.rd_valid, vecs[i].e_count != 0);
      check($sformatf("vec%0d_overflow", i), bus.overflow, vecs[i].e_ovf);
      if (vecs[i].e_head)
        check($sformatf("vec%0d_head", i), {bus.rd_timestamp, bus.rd_tag},
              {vecs[i].e_ts, vecs[i].e_tag});
    end

    // Basic run with a slow-starting, slow-stopping counter.
    start_lat = 3; stop_lat = 2;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("basic_ts_start", bus.ts_start, 1'b1);
    wait_cnt(64'd10); step(1'b0, 1'b1, 1'b0, 8'h05, 1'b0);
    wait_cnt(64'd25); step(1'b0, 1'b1, 1'b0, 8'h06, 1'b0);
    wait_cnt(64'd40); step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("basic_stop_cmd", bus.ts_command, CMD_STOP);
    wait_idle();
    check("basic_count3", bus.count, 3);
    read_expect("basic_rec0", 64'd10, 8'h05);
    read_expect("basic_rec1", 64'd25, 8'h06);
    read_expect("basic_rec2", 64'd42, 8'hFF);
    check("basic_count0", bus.count, 0);

    // Same-cycle sample and stop.
    start_lat = 0; stop_lat = 0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_cnt(64'd7);
    step(1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    wait_idle();
    check("samestop_count", bus.count, 2);
    read_expect("samestop_rec0", 64'd7, 8'h11);
    read_expect("samestop_rec1", 64'd7, 8'hFF);

    // Overflow: five samples, fifth dropped; marker dropped too; restart clears.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_step(); idle_step();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    check("ovf_count", bus.count, 4);
    check("ovf_flag", bus.overflow, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_tag%0d", i), bus.rd_tag, 8'(8'h20 + i));
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("ovf_drained", bus.rd_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("ovf_cleared", bus.overflow, 1'b0);
    idle_step(); idle_step();

    // Full with simultaneous read/write, then three fill/drain passes for wrap.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h44, 1'b1);
    check("fullrw_count", bus.count, 4);
    check("fullrw_ovf", bus.overflow, 1'b0);
    check("fullrw_head", bus.rd_tag, 8'h41);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(p * 16 + i), 1'b0);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("wrap_p%0d_%0d", p, i), bus.rd_tag, 8'(p * 16 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    wait_idle();

    // Asynchronous reset while holding the stop command.
    stop_lat = 20;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_step(); idle_step();
    step(1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h56, 1'b0);
    check("arst_pre_cmd", bus.ts_command, CMD_STOP);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cmd", bus.ts_command, CMD_NOP);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_rd_valid", bus.rd_valid, 1'b0);
    @(negedge clk);
    stop_lat = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("arst_restart", bus.ts_start, 1'b1);

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      start_lat = $urandom_range(0, 3);
      stop_lat  = $urandom_range(0, 3);
      for (int c = 0; c < 60; c++)
        step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 29) == 0, 8'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prof_cmd_issuer.md
Name: prof_cmd_issuer

Overview:
- Initiator side of the profiling-counter command interface.
- Converts host profiling requests (start, sample, stop) into the counter unit's start pulse and 4-bit command protocol.
- Captures the 64-bit timestamp on each sample and on stop into a tagged first-word-fall-through record FIFO for host readout.
- Sits between the kernel-side profiling control logic and the cycle-counter unit.

Parameters:
- DEPTH, 16, number of record FIFO entries; must be a power of 2, minimum 2.
- TAGW, 8, width of the per-record tag; the all-ones tag is reserved as the end-of-run marker.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_start  in  1  begin a profiling run; honoured only in IDLE.
- host_sample  in  1  record the current timestamp; honoured only in RUN.
- host_tag  in  TAGW  tag stored with a sample record.
- host_stop  in  1  end the run; honoured only in RUN.
- busy  out  1  high whenever the state is not IDLE.
- ts_start  out  1  start pulse to the counter unit.
- ts_command  out  4  command to the counter unit: 0x0 = no-op, 0x2 = stop.
- ts_done  in  1  counter unit idle indication.
- ts_timestamp  in  64  current counter value.
- rd_valid  out  1  FIFO not empty.
- rd_en  in  1  pop the head record; ignored when rd_valid=0.
- rd_timestamp  out  64  timestamp of the head record.
- rd_tag  out  TAGW  tag of the head record.
- count  out  $clog2(DEPTH)+1  number of records held.
- overflow  out  1  sticky flag: a record was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous assert, all registers): state=IDLE, ts_start=0, ts_command=0x0, FIFO empty, count=0, overflow=0, busy=0, rd_valid=0.
- All outputs to the counter unit are registered. ts_command is 0x0 except in STOP.
- IDLE: on host_start, the next state is ARM. In the same edge the FIFO is flushed (pointers and count to 0) and overflow is cleared. A flush overrides any rd_en in that cycle.
- ARM: ts_start=1 for exactly this one cycle. The next state is SYNC.
- SYNC: wait for ts_done=0, which means the counter is now counting. Then go to RUN.
- RUN:
  - host_sample=1 writes {ts_timestamp, host_tag} as seen in that cycle. There is no added latency.
  - host_stop=1 moves the next state to STOP.
  - host_sample and host_stop in the same cycle: the sample is written, then STOP is entered.
- STOP: ts_command=0x2 is held until ts_done=1 is sampled.
  - In that cycle, write {ts_timestamp, all-ones tag} as the end-of-run marker.
  - The next state is IDLE.
  - ts_command returns to 0x0 in the IDLE cycle.
- Any undefined state encoding moves to IDLE with ts_start=0 and ts_command=0.
- host_start outside IDLE, and host_sample or host_stop outside RUN, are ignored with no side effect.
- FIFO:
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally.
  - count is updated by +1 on a write only, -1 on a read only, and unchanged when both happen.
  - Write when full with no read in the same cycle: the record is dropped, overflow is set, and count is unchanged.
  - Write when full with rd_en=1 in the same cycle: both are accepted.
  - Read when empty: no effect.
- rd_timestamp and rd_tag show the head entry combinationally from storage. Their value is undefined while rd_valid=0.
- A sample's tag may equal all-ones. The host distinguishes the end marker only by its position (the last record of a run).

Decomposition:
- Shared package prof_pkg:
  - counter command encodings (CMD_NOP=4'h0, CMD_STOP=4'h2);
  - state enum (IDLE, ARM, SYNC, RUN, STOP);
  - END_TAG function of TAGW;
  - timestamp width constant TS_W=64.
- One sub-module: prof_rec_fifo. It is the FWFT FIFO parameterised by DEPTH and data width TS_W+TAGW, with flush, count and overflow.

Test Plan:
- Basic run: reset, host_start -> ts_start high for exactly 1 cycle, 1 cycle after start accepted. A counter model drops ts_done. Sample with tag 0x05 at counter 10 and tag 0x06 at counter 25; host_stop at counter 40 -> ts_command=0x2 until ts_done=1. Readout gives (10,0x05), (25,0x06), (final value,0xFF); count goes 3->0; busy returns to 0.
- Ignored requests: host_sample and host_stop in IDLE, host_start in RUN -> no records, no extra ts_start, state sequence unchanged.
- Overflow, DEPTH=4: 5 samples with no reads -> count=4, overflow=1, and the 5th record is absent. A new host_start -> count=0, overflow=0.
- Full with simultaneous read and write: FIFO full, rd_en and host_sample in the same cycle -> count stays 4, overflow stays 0, the oldest record is popped and the new one is appended. Also cover pointer wrap over 3 full fill/drain passes.
- Same-cycle sample+stop: sample tag 0x11 at counter 7 together with host_stop -> record (7,0x11) followed by the end-marker record.
- Asynchronous reset mid-run (in STOP, with ts_command=0x2): outputs drop immediately to ts_command=0, busy=0, rd_valid=0. After release, host_start works normally.
